// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the 8-bit CPU.
// Optional single-instruction stepping when CPU_SEQ_STEP_EN is defined.
module cpu_sequencer #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef CPU_SEQ_STEP_EN
  input  logic             step,
`endif
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [7:0]       imem_data,
  output logic [2:0]       alu_op,
  output logic [1:0]       rf_ra,
  output logic [1:0]       rf_rb,
  output logic [1:0]       rf_wa,
  output logic             rf_we,
  output logic [PC_W-1:0]  pc,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FETCH     = 3'd1;
  localparam logic [2:0] DECODE    = 3'd2;
  localparam logic [2:0] EXECUTE   = 3'd3;
  localparam logic [2:0] WRITEBACK = 3'd4;
  localparam logic [2:0] HALT      = 3'd5;

  localparam logic [PC_W-1:0]  PC_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]       state_reg, state_next;
  logic [7:0]       ir_reg;
  logic [2:0]       alu_op_reg;
  logic             we_flag_reg;
  logic [PC_W-1:0]  pc_reg;
  logic             halted_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [2:0] dec_op;
  logic       dec_we;
  logic       dec_illegal;
  logic       dec_halt;
  logic       go;

`ifdef CPU_SEQ_STEP_EN
  assign go = start | step;
`else
  assign go = start;
`endif

  // Illegal opcodes decode to a NOP so the instruction still retires.
  always_comb begin
    dec_op      = 3'b000;
    dec_we      = 1'b0;
    dec_illegal = 1'b0;
    dec_halt    = 1'b0;
    case (ir_reg[7:4])
      4'h0: ;
      4'h1: begin dec_op = 3'b000; dec_we = 1'b1; end
      4'h2: begin dec_op = 3'b001; dec_we = 1'b1; end
      4'h3: begin dec_op = 3'b010; dec_we = 1'b1; end
      4'h4: begin dec_op = 3'b011; dec_we = 1'b1; end
      4'h5: begin dec_op = 3'b100; dec_we = 1'b1; end
      4'h6: begin dec_op = 3'b101; dec_we = 1'b1; end
      4'h7: begin dec_op = 3'b110; dec_we = 1'b1; end
      4'h8: begin dec_op = 3'b111; dec_we = 1'b1; end
      4'hF: dec_halt = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (go) state_next = FETCH;
      FETCH:     if (imem_ack) state_next = DECODE;
      DECODE:    state_next = dec_halt ? HALT : EXECUTE;
      EXECUTE:   state_next = WRITEBACK;
`ifdef CPU_SEQ_STEP_EN
      WRITEBACK: state_next = IDLE;
`else
      WRITEBACK: state_next = FETCH;
`endif
      HALT:      state_next = HALT;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      ir_reg      <= 8'h00;
      alu_op_reg  <= 3'b000;
      we_flag_reg <= 1'b0;
      pc_reg      <= '0;
      halted_reg  <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == FETCH && imem_ack)
        ir_reg <= imem_data;
      if (state_reg == DECODE) begin
        alu_op_reg  <= dec_op;
        we_flag_reg <= dec_we;
        if (dec_halt) begin
          halted_reg <= 1'b1;
          if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CNT_ONE;
        end
      end
      if (state_reg == WRITEBACK) begin
        pc_reg <= pc_reg + PC_ONE;
        if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CNT_ONE;
      end
    end
  end

  // Register addresses follow the instruction register, which only changes
  // on the fetch-ack edge, i.e. exactly at the start of the next DECODE.
  assign imem_req    = (state_reg == FETCH);
  assign imem_addr   = pc_reg;
  assign alu_op      = alu_op_reg;
  assign rf_ra       = ir_reg[3:2];
  assign rf_rb       = ir_reg[1:0];
  assign rf_wa       = ir_reg[3:2];
  assign rf_we       = (state_reg == WRITEBACK) && we_flag_reg;
  assign pc          = pc_reg;
  assign halted      = halted_reg;
  assign illegal     = (state_reg == DECODE) && dec_illegal;
  assign instr_count = cnt_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: timing, decode, stall, illegal, halt, pc wrap.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, imem_ack;
  logic [7:0]  imem_data;
  logic        imem_req, rf_we, halted, illegal;
  logic [7:0]  imem_addr, pc;
  logic [2:0]  alu_op;
  logic [1:0]  rf_ra, rf_rb, rf_wa;
  logic [15:0] instr_count;

  logic        reset2, start2, imem_ack2;
  logic [7:0]  imem_data2;
  logic        imem_req2, rf_we2, halted2, illegal2;
  logic [1:0]  imem_addr2, pc2;
  logic [2:0]  alu_op2;
  logic [1:0]  rf_ra2, rf_rb2, rf_wa2;
  logic [15:0] instr_count2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.PC_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .alu_op(alu_op), .rf_ra(rf_ra), .rf_rb(rf_rb),
    .rf_wa(rf_wa), .rf_we(rf_we), .pc(pc), .halted(halted),
    .illegal(illegal), .instr_count(instr_count)
  );

  cpu_sequencer #(.PC_W(2), .CNT_W(16)) dut2 (
    .clk(clk), .reset(reset2), .start(start2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2),
    .imem_data(imem_data2), .alu_op(alu_op2), .rf_ra(rf_ra2), .rf_rb(rf_rb2),
    .rf_wa(rf_wa2), .rf_we(rf_we2), .pc(pc2), .halted(halted2),
    .illegal(illegal2), .instr_count(instr_count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered in FETCH with imem_ack=1; leaves the DUT back in FETCH.
  task automatic run_instr(input logic [7:0] data, input logic [2:0] exp_op,
                           input logic exp_we, input logic exp_ill);
    imem_data = data;
    tick();
    check("dec_illegal", illegal, exp_ill);
    check("dec_rf_we", rf_we, 1'b0);
    check("dec_rf_wa", rf_wa, data[3:2]);
    check("dec_rf_rb", rf_rb, data[1:0]);
    tick();
    check("exe_rf_we", rf_we, 1'b0);
    tick();
    check("wb_rf_we", rf_we, exp_we);
    check("wb_alu_op", alu_op, exp_op);
    check("wb_illegal", illegal, 1'b0);
    tick();
    check("post_rf_we", rf_we, 1'b0);
    $display("instr %02h: pc=%0d count=%0d", data, pc, instr_count);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; imem_ack = 1'b1; imem_data = 8'h00;
    reset2 = 1'b1; start2 = 1'b0; imem_ack2 = 1'b1; imem_data2 = 8'h16;
    tick(); tick();
    reset = 1'b0;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_pc", pc, 8'd0);
    check("rst_halted", halted, 1'b0);
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_alu_op", alu_op, 3'b000);
    check("rst_count", instr_count, 16'd0);
    tick();
    check("idle_req", imem_req, 1'b0);

    // ADD r1,r2: FETCH is cycle 1, WRITEBACK cycle 4
    start = 1'b1; tick(); start = 1'b0;
    check("fetch_req", imem_req, 1'b1);
    check("fetch_addr", imem_addr, 8'd0);
    run_instr(8'h16, 3'b000, 1'b1, 1'b0);
    check("add_pc", pc, 8'd1);
    check("add_count", instr_count, 16'd1);

    // Illegal then NOP: neither writes, pc advances by 2
    run_instr(8'hA5, 3'b000, 1'b0, 1'b1);
    run_instr(8'h00, 3'b000, 1'b0, 1'b0);
    check("ill_pc", pc, 8'd3);

    // HALT at pc=3
    imem_data = 8'hF0;
    tick();
    check("halt_dec_illegal", illegal, 1'b0);
    tick();
    check("halted", halted, 1'b1);
    check("halt_pc", pc, 8'd3);
    check("halt_count", instr_count, 16'd4);
    for (int i = 0; i < 20; i++) begin
      check("halt_req", imem_req, 1'b0);
      tick();
    end
    check("halt_pc_hold", pc, 8'd3);
    check("halt_count_hold", instr_count, 16'd4);
    $display("halt: pc=%0d count=%0d", pc, instr_count);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_halted2", halted, 1'b0);
    check("rst_pc2", pc, 8'd0);

    // Stall 5 cycles, then SUB..SHR
    start = 1'b1; tick(); start = 1'b0;
    imem_ack = 1'b0; imem_data = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      check("stall_req", imem_req, 1'b1);
      check("stall_addr", imem_addr, 8'd0);
      check("stall_rf_ra", rf_ra, 2'd0);
      check("stall_rf_we", rf_we, 1'b0);
      tick();
    end
    check("stall_req6", imem_req, 1'b1);
    imem_ack = 1'b1;
    run_instr(8'h2D, 3'b001, 1'b1, 1'b0);
    run_instr(8'h31, 3'b010, 1'b1, 1'b0);
    run_instr(8'h46, 3'b011, 1'b1, 1'b0);
    run_instr(8'h5B, 3'b100, 1'b1, 1'b0);
    run_instr(8'h6C, 3'b101, 1'b1, 1'b0);
    run_instr(8'h72, 3'b110, 1'b1, 1'b0);
    run_instr(8'h8F, 3'b111, 1'b1, 1'b0);
    check("seq_count", instr_count, 16'd7);
    check("seq_pc", pc, 8'd7);

    // Reset mid-fetch
    imem_ack = 1'b0; tick();
    check("midfetch_req", imem_req, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("midrst_req", imem_req, 1'b0);
    check("midrst_pc", pc, 8'd0);
    check("midrst_count", instr_count, 16'd0);
    tick(); tick();
    check("midrst_idle", imem_req, 1'b0);

    // PC_W=2 wrap with back-to-back ADDs
    reset2 = 1'b0;
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] exp_pc;
      exp_pc = 2'(k + 1);
      tick(); tick(); tick(); tick();
      check("wrap_pc", pc2, exp_pc);
      $display("wrap instr %0d: pc=%0d", k, pc2);
    end
    check("wrap_count", instr_count2, 16'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle instruction sequencer for the 8-bit CPU.
- Fetches 8-bit instruction words from instruction memory over a req/ack handshake and steps each instruction through FETCH, DECODE, EXECUTE and WRITEBACK.
- Decodes the opcode into the 3-bit ALU op and register-file write enable, and drives register-file addresses, the program counter, halt and illegal-opcode status.
- Sits between instruction memory and the ALU/register-file datapath.

Parameters:
PC_W, 8, program counter and imem_addr width
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  system clock; the only clock in the block
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; leaves IDLE
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch address; equals pc
imem_ack  in  1  fetch accepted; imem_data valid this cycle
imem_data  in  8  instruction word: [7:4] opcode, [3:2] rd, [1:0] rs
alu_op  out  3  ALU operation select
rf_ra  out  2  register-file read port A address (rd)
rf_rb  out  2  register-file read port B address (rs)
rf_wa  out  2  register-file write address (rd)
rf_we  out  1  register-file write strobe, one cycle
pc  out  PC_W  program counter
halted  out  1  sticky; HALT executed
illegal  out  1  one-cycle pulse on an undefined opcode
instr_count  out  CNT_W  retired instructions

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (reset). It is sampled only on the rising edge of clk.
- Reset values: state=IDLE, pc=0, imem_req=0, alu_op=000, rf_ra/rf_rb/rf_wa=0, rf_we=0, halted=0, illegal=0, instr_count=0, instruction register=0.
- Reset asserted in any state, including mid-fetch with imem_req high, takes effect at that edge. imem_req is 0 the following cycle.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE: outputs quiescent. start=1 moves to FETCH. start is ignored in all other states.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until ack.
  - On imem_req&&imem_ack, latch imem_data into the instruction register, drop imem_req next cycle, and go to DECODE.
  - With ack tied high, FETCH lasts 1 cycle.
- DECODE (1 cycle):
  - Register alu_op and the write-enable flag from the opcode: 0000 NOP (000, no write); 0001 ADD 000; 0010 SUB 001; 0011 AND 010; 0100 OR 011; 0101 XOR 100; 0110 NOT 101; 0111 SHL 110; 1000 SHR 111. Opcodes 0001–1000 write.
  - Opcode 1111 is HALT and goes to HALT.
  - Opcodes 1001–1110 are illegal: illegal pulses in this cycle, and the instruction is executed as a NOP.
  - rf_ra=rd, rf_rb=rs, rf_wa=rd from this cycle until the next DECODE.
- EXECUTE (1 cycle): alu_op is held stable for the datapath to settle.
- WRITEBACK (1 cycle):
  - rf_we=1 only if the decoded write flag is set.
  - pc increments by 1, wrapping from 2^PC_W-1 to 0.
  - instr_count increments, saturating at all-ones.
  - Next state is FETCH.
- Throughput: 4 cycles per instruction with zero-wait memory.
- HALT:
  - Entered from DECODE. halted=1 from the next cycle.
  - pc is not incremented and instr_count is incremented.
  - No further fetches; exited only by reset.
- rf_we and illegal are never high in the same cycle. rf_we is never asserted outside WRITEBACK.

Optional Feature:
- Macro: CPU_SEQ_STEP_EN.
- When defined:
  - Adds input step (1 bit).
  - From WRITEBACK, the sequencer enters IDLE instead of FETCH, and the next instruction needs a start or step pulse.
  - step in IDLE behaves identically to start.
  - This gives single-instruction stepping for debug.
- When undefined: no step port, and WRITEBACK always goes to FETCH.

Test Plan:
- Reset, then start; imem_ack tied 1; imem_data=0x1_6 (ADD r1,r2) -> rf_we high exactly at cycle 4 after FETCH entry, alu_op=000, rf_wa=1, rf_rb=2, pc=1, instr_count=1.
- Program SUB, AND, OR, XOR, NOT, SHL, SHR -> alu_op sequence 001,010,011,100,101,110,111, each with one rf_we pulse; instr_count=7.
- imem_ack held low 5 cycles during FETCH -> imem_req and imem_addr stable for 6 cycles; instruction latched only on the ack cycle; no rf_we before it.
- Opcode 1010, then NOP 0x00 -> illegal pulses once in DECODE, no rf_we for either; pc advances by 2.
- Opcode 0xF0 at pc=3 -> halted=1, pc stays 3, imem_req stays 0 for 20 cycles, instr_count increments once; reset clears halted and pc.
- PC_W=2 with 5 ADDs -> pc sequence 1,2,3,0,1. Reset asserted while imem_req=1 -> next cycle state=IDLE, imem_req=0, pc=0.
